// File: rtl/axi4_resp_pkg.sv
// Shared types and encodings for the AXI4 SRAM responder.
package axi4_resp_pkg;
  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_e;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
endpackage

// File: rtl/axi4_rd_skid.sv
// Two-entry read-data buffer; passes input straight through when empty so
// SRAM data reaches the R channel the cycle it appears.
module axi4_rd_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] buf_q, buf_d;
  logic              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              store, pop;

  assign count = cnt_q;

  always_comb begin
    buf_d     = buf_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    in_ready  = cnt_q != 2'd2;
    out_valid = (cnt_q != 2'd0) || in_valid;
    out_data  = (cnt_q != 2'd0) ? buf_q[rd_ptr_q] : (in_valid ? in_data : '0);
    // Bypassed beats that are consumed immediately never occupy an entry.
    store     = in_valid && in_ready && !((cnt_q == 2'd0) && out_ready);
    pop       = (cnt_q != 2'd0) && out_ready;
    if (store) begin
      buf_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, store} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_q    <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      buf_q    <= buf_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 slave serving one burst at a time from a single-port SRAM with a
// one-cycle read latency; reads stream through axi4_rd_skid.
module axi4_mem_responder
  import axi4_resp_pkg::*;
#(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              axi4_awvalid,
  output logic              axi4_awready,
  input  logic [AW-1:0]     axi4_awaddr,
  input  logic [7:0]        axi4_awlen,
  input  logic [2:0]        axi4_awsize,
  input  logic [1:0]        axi4_awburst,
  input  logic              axi4_wvalid,
  output logic              axi4_wready,
  input  logic [DW-1:0]     axi4_wdata,
  input  logic [DW/8-1:0]   axi4_wstrb,
  input  logic              axi4_wlast,
  output logic              axi4_bvalid,
  input  logic              axi4_bready,
  output logic [1:0]        axi4_bresp,
  input  logic              axi4_arvalid,
  output logic              axi4_arready,
  input  logic [AW-1:0]     axi4_araddr,
  input  logic [7:0]        axi4_arlen,
  input  logic [2:0]        axi4_arsize,
  input  logic [1:0]        axi4_arburst,
  output logic              axi4_rvalid,
  input  logic              axi4_rready,
  output logic [DW-1:0]     axi4_rdata,
  output logic              axi4_rlast,
  output logic              mem_en,
  output logic [DW/8-1:0]   mem_bwe,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);
  localparam int SW  = DW / 8;
  localparam int OFF = $clog2(SW);

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d, addr_nxt;
  logic [7:0]        len_q, len_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [1:0]        burst_q, burst_d;
  logic              oor_q, oor_d, err_q, err_d, fav_w_q, fav_w_d;
  logic              pend_q, pend_d, pend_last_q, pend_last_d;
  logic              grant_w, grant_r, wr_beat, beat_last, rd_issue;
  logic [1:0]        skid_cnt;
  logic              skid_in_ready;
  logic [DW:0]       skid_out;
  logic [DW-1:0]     rd_word;
  logic              unused_ok;

  function automatic logic out_of_range(input logic [AW-1:0] a);
    return (a >> (MEM_AW + OFF)) != '0;
  endfunction

  assign grant_w      = axi4_awvalid && (!axi4_arvalid || fav_w_q);
  assign grant_r      = axi4_arvalid && !grant_w;
  // Grants are combinational from IDLE, so they must be masked while in reset.
  assign axi4_awready = rstn && (state_q == IDLE) && grant_w;
  assign axi4_arready = rstn && (state_q == IDLE) && grant_r;
  assign axi4_wready  = state_q == WR_DATA;
  assign wr_beat      = axi4_wready && axi4_wvalid;
  assign beat_last    = cnt_q == {1'b0, len_q};
  assign addr_nxt     = (burst_q == FIXED) ? addr_q : addr_q + MEM_AW'(1);
  // At most one read is in flight; issue only if the buffer can absorb it.
  assign rd_issue     = (state_q == RD_DATA) && (cnt_q <= {1'b0, len_q})
                        && ((skid_cnt + {1'b0, pend_q}) < 2'd2);

  assign mem_en      = (wr_beat || rd_issue) && !oor_q;
  assign mem_bwe     = (wr_beat && !oor_q) ? axi4_wstrb : '0;
  assign mem_wdata   = (wr_beat && !oor_q) ? axi4_wdata : '0;
  assign mem_addr    = addr_q;
  assign axi4_bvalid = state_q == WR_RESP;
  assign axi4_bresp  = (axi4_bvalid && (oor_q || err_q)) ? SLVERR : OKAY;
  assign rd_word     = oor_q ? '0 : mem_rdata;

  axi4_rd_skid #(.W(DW + 1)) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (pend_q),
    .in_ready  (skid_in_ready),
    .in_data   ({pend_last_q, rd_word}),
    .out_valid (axi4_rvalid),
    .out_ready (axi4_rready),
    .out_data  (skid_out),
    .count     (skid_cnt)
  );
  assign {axi4_rlast, axi4_rdata} = skid_out;

  assign unused_ok = ^{axi4_awsize, axi4_arsize, axi4_awaddr[OFF-1:0],
                       axi4_araddr[OFF-1:0], skid_in_ready};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    burst_d     = burst_q;
    oor_d       = oor_q;
    err_d       = err_q;
    fav_w_d     = fav_w_q;
    pend_d      = rd_issue;
    pend_last_d = rd_issue && beat_last;
    case (state_q)
      IDLE: begin
        if (axi4_awready) begin
          addr_d  = axi4_awaddr[MEM_AW+OFF-1:OFF];
          len_d   = axi4_awlen;
          burst_d = axi4_awburst;
          oor_d   = out_of_range(axi4_awaddr);
          err_d   = 1'b0;
          cnt_d   = '0;
          fav_w_d = 1'b0;
          state_d = WR_DATA;
        end else if (axi4_arready) begin
          addr_d  = axi4_araddr[MEM_AW+OFF-1:OFF];
          len_d   = axi4_arlen;
          burst_d = axi4_arburst;
          oor_d   = out_of_range(axi4_araddr);
          err_d   = 1'b0;
          cnt_d   = '0;
          fav_w_d = 1'b1;
          state_d = RD_DATA;
        end
      end
      WR_DATA: begin
        if (wr_beat) begin
          addr_d = addr_nxt;
          cnt_d  = cnt_q + 9'd1;
          if (axi4_wlast != beat_last) err_d = 1'b1;
          if (beat_last) state_d = WR_RESP;
        end
      end
      WR_RESP: if (axi4_bready) state_d = IDLE;
      RD_DATA: begin
        if (rd_issue) begin
          addr_d = addr_nxt;
          cnt_d  = cnt_q + 9'd1;
        end
        if (axi4_rvalid && axi4_rready && axi4_rlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      burst_q     <= '0;
      oor_q       <= 1'b0;
      err_q       <= 1'b0;
      fav_w_q     <= 1'b1;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      burst_q     <= burst_d;
      oor_q       <= oor_d;
      err_q       <= err_d;
      fav_w_q     <= fav_w_d;
      pend_q      <= pend_d;
      pend_last_q <= pend_last_d;
    end
  end
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Randomized and directed bench for axi4_mem_responder against a word-array
// memory model and a simple arbitration model.
module tb_axi4_mem_responder;
  logic clk = 1'b0, rstn = 1'b1;
  always #5 clk = ~clk;

  logic        awvalid = 0, awready, wvalid = 0, wready, wlast = 0, bvalid, bready = 0;
  logic        arvalid = 0, arready, rvalid, rready = 0, rlast, mem_en;
  logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata, mem_wdata, mem_rdata;
  logic [7:0]  awlen = 0, arlen = 0;
  logic [2:0]  awsize = 3'd2, arsize = 3'd2;
  logic [1:0]  awburst = 1, arburst = 1, bresp;
  logic [3:0]  wstrb = 0, mem_bwe;
  logic [11:0] mem_addr;

  axi4_mem_responder #(.DW(32), .AW(32), .MEM_AW(12)) dut (
    .clk(clk), .rstn(rstn),
    .axi4_awvalid(awvalid), .axi4_awready(awready), .axi4_awaddr(awaddr),
    .axi4_awlen(awlen), .axi4_awsize(awsize), .axi4_awburst(awburst),
    .axi4_wvalid(wvalid), .axi4_wready(wready), .axi4_wdata(wdata),
    .axi4_wstrb(wstrb), .axi4_wlast(wlast),
    .axi4_bvalid(bvalid), .axi4_bready(bready), .axi4_bresp(bresp),
    .axi4_arvalid(arvalid), .axi4_arready(arready), .axi4_araddr(araddr),
    .axi4_arlen(arlen), .axi4_arsize(arsize), .axi4_arburst(arburst),
    .axi4_rvalid(rvalid), .axi4_rready(rready), .axi4_rdata(rdata), .axi4_rlast(rlast),
    .mem_en(mem_en), .mem_bwe(mem_bwe), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] sram [4096];
  logic [31:0] ref_mem [4096];
  logic [11:0] rd_q [$];
  int          en_cnt = 0, errs = 0, checks = 0;
  longint      cyc = 0;
  logic        tb_last_w = 1'b0;

  always @(posedge clk) begin
    logic [31:0] t;
    cyc++;
    if (mem_en) begin
      en_cnt++;
      if (mem_bwe != 4'h0) begin
        t = sram[mem_addr];
        for (int b = 0; b < 4; b++) if (mem_bwe[b]) t[8*b +: 8] = mem_wdata[8*b +: 8];
        sram[mem_addr] <= t;
      end else begin
        mem_rdata <= sram[mem_addr];
        rd_q.push_back(mem_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] word_of(input logic [31:0] a);
    return 12'((a / 4) % 4096);
  endfunction

  function automatic bit oor_of(input logic [31:0] a);
    return a >= 32'h4000;
  endfunction

  task automatic wr_addr(input logic [31:0] a, input int len, input logic [1:0] bt);
    int n = 0;
    @(negedge clk);
    awvalid = 1; awaddr = a; awlen = 8'(len); awburst = bt;
    #1;
    while (!awready && n < 100) begin @(negedge clk); #1; n++; end
    chk("aw_ready", awready, 1);
    tb_last_w = 1'b1;
    @(negedge clk);
    awvalid = 0;
  endtask

  task automatic wr_data(input logic [31:0] a0, input int len, input logic [1:0] bt,
                         input int wlast_at, input logic [31:0] fixed, output logic [1:0] resp);
    logic [11:0] a = word_of(a0);
    bit oor = oor_of(a0), err = 0;
    int n;
    for (int b = 0; b <= len; b++) begin
      while ($urandom_range(0, 3) == 0) begin wvalid = 0; @(negedge clk); end
      wvalid = 1;
      wdata  = (fixed != 0) ? fixed : $urandom;
      wstrb  = (fixed != 0) ? 4'hF : 4'($urandom_range(1, 15));
      wlast  = (b == wlast_at);
      #1; n = 0;
      while (!wready && n < 100) begin @(negedge clk); #1; n++; end
      chk("w_ready", wready, 1);
      chk("w_mem_en", mem_en, !oor);
      if (!oor) begin
        chk("w_mem_addr", mem_addr, a);
        chk("w_mem_bwe", mem_bwe, wstrb);
        chk("w_mem_wdata", mem_wdata, wdata);
        for (int k = 0; k < 4; k++) if (wstrb[k]) ref_mem[a][8*k +: 8] = wdata[8*k +: 8];
      end
      if (wlast != (b == len)) err = 1;
      if (bt != 2'b00) a = 12'((a + 1) % 4096);
      @(negedge clk);
    end
    wvalid = 0; wlast = 0;
    #1;
    chk("b_valid", bvalid, 1);
    repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; chk("b_hold", bvalid, 1); end
    bready = 1; #1;
    resp = bresp;
    chk("b_resp", bresp, (oor || err) ? 2'b10 : 2'b00);
    @(negedge clk);
    bready = 0; #1;
    chk("b_done", bvalid, 0);
  endtask

  task automatic rd_addr(input logic [31:0] a, input int len, input logic [1:0] bt,
                         output longint hs);
    int n = 0;
    @(negedge clk);
    arvalid = 1; araddr = a; arlen = 8'(len); arburst = bt;
    #1;
    while (!arready && n < 100) begin @(negedge clk); #1; n++; end
    chk("ar_ready", arready, 1);
    hs = cyc;
    tb_last_w = 1'b0;
    @(negedge clk);
    arvalid = 0;
  endtask

  // mode: 0 rready high, 1 toggling, 2 random
  task automatic rd_data(input logic [31:0] a0, input int len, input logic [1:0] bt,
                         input int mode, input longint hs);
    logic [11:0] a = word_of(a0);
    bit oor = oor_of(a0), first = 1, held = 0, tog = 1, hl = 0;
    logic [31:0] hd = 0;
    int beat = 0, n = 0;
    while (beat <= len && n < 2000) begin
      rready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      #1;
      if (rvalid && first) begin chk("r_latency", cyc - hs, 2); first = 0; end
      if (held) begin
        chk("r_hold_valid", rvalid, 1);
        chk("r_hold_data", rdata, hd);
        chk("r_hold_last", rlast, hl);
        held = 0;
      end
      if (rvalid && rready) begin
        chk("r_data", rdata, oor ? 32'h0 : ref_mem[a]);
        chk("r_last", rlast, beat == len);
        beat++;
        if (bt != 2'b00) a = 12'((a + 1) % 4096);
      end else if (rvalid) begin
        held = 1; hd = rdata; hl = rlast;
      end
      @(negedge clk); n++;
    end
    rready = 0;
    chk("r_beats", beat, len + 1);
    #1;
    chk("r_done", rvalid, 0);
  endtask

  task automatic arb_probe(input logic [31:0] wa, input logic [31:0] ra, output logic got_w);
    logic [1:0] resp;
    longint hs;
    bit exp_w = !tb_last_w;
    @(negedge clk);
    awvalid = 1; awaddr = wa; awlen = 0; awburst = 1;
    arvalid = 1; araddr = ra; arlen = 0; arburst = 1;
    #1;
    chk("arb_aw", awready, exp_w);
    chk("arb_ar", arready, !exp_w);
    got_w = awready;
    tb_last_w = got_w;
    hs = cyc;
    @(negedge clk);
    awvalid = 0; arvalid = 0;
    if (got_w) wr_data(wa, 0, 1, 0, 0, resp);
    else       rd_data(ra, 0, 1, 0, hs);
  endtask

  initial begin
    logic [1:0] resp;
    longint hs;
    logic g0, g1, g2;
    int snap, beat, n;
    for (int i = 0; i < 4096; i++) begin sram[i] = $urandom; ref_mem[i] = sram[i]; end

    #1 rstn = 0;
    awvalid = 1; arvalid = 1;
    #2;
    chk("rst_ready", {awready, arready, wready}, 0);
    chk("rst_outs", {bvalid, bresp, rvalid, rlast}, 0);
    chk("rst_mem", {mem_en, mem_bwe, mem_addr}, 0);
    chk("rst_data", {rdata, mem_wdata}, 0);
    awvalid = 0; arvalid = 0;
    repeat (3) @(negedge clk);
    rstn = 1;

    // single write then read-back
    wr_addr(32'h10, 0, 1);
    wr_data(32'h10, 0, 1, 0, 32'hA5A5A5A5, resp);
    chk("single_bresp", resp, 2'b00);
    chk("single_ref", ref_mem[4], 32'hA5A5A5A5);
    rd_addr(32'h10, 0, 1, hs);
    rd_data(32'h10, 0, 1, 0, hs);

    // 8-beat INCR read with rready toggling
    rd_addr(32'h0, 7, 1, hs);
    rd_data(32'h0, 7, 1, 1, hs);

    // round-robin from reset: W, R, W
    @(negedge clk); rstn = 0; tb_last_w = 0;
    @(negedge clk); rstn = 1;
    arb_probe(32'h40, 32'h80, g0);
    arb_probe(32'h44, 32'h84, g1);
    arb_probe(32'h48, 32'h88, g2);
    chk("arb_seq", {g0, g1, g2}, 3'b101);

    // early wlast: beats still counted, response is SLVERR
    snap = en_cnt;
    wr_addr(32'h100, 3, 1);
    wr_data(32'h100, 3, 1, 1, 0, resp);
    chk("wlast_resp", resp, 2'b10);
    chk("wlast_beats", en_cnt - snap, 4);

    // out-of-range write touches no SRAM
    snap = en_cnt;
    wr_addr(32'h10000, 1, 1);
    wr_data(32'h10000, 1, 1, 1, 0, resp);
    chk("oor_resp", resp, 2'b10);
    chk("oor_no_mem", en_cnt - snap, 0);

    // FIXED read holds the word address
    rd_q.delete();
    rd_addr(32'h8, 3, 0, hs);
    rd_data(32'h8, 3, 0, 2, hs);
    chk("fixed_nreads", rd_q.size(), 4);
    foreach (rd_q[i]) chk("fixed_addr", rd_q[i], 12'd2);

    // randomized mix
    for (int t = 0; t < 30; t++) begin
      logic [31:0] a;
      int len = $urandom_range(0, 7), wl;
      logic [1:0] bt = 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 7) == 0) ? 32'h4000 + 4 * $urandom_range(0, 255)
                                      : 4 * $urandom_range(0, 4095);
      if ($urandom_range(0, 1) == 1) begin
        wl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : len;
        wr_addr(a, len, bt);
        wr_data(a, len, bt, wl, 0, resp);
      end else begin
        rd_addr(a, len, bt, hs);
        rd_data(a, len, bt, $urandom_range(0, 2), hs);
      end
    end

    // reset during beat 3 of a 16-beat read
    rd_addr(32'h0, 15, 1, hs);
    beat = 0; n = 0; rready = 1;
    while (beat < 2 && n < 100) begin
      #1;
      if (rvalid) begin chk("rst_rd_data", rdata, ref_mem[beat]); beat++; end
      @(negedge clk); n++;
    end
    chk("rst_rd_pre", beat, 2);
    #1;
    chk("rst_rd_beat3", rvalid, 1);
    snap = en_cnt;
    rstn = 0; rready = 0;
    awvalid = 1; awaddr = 32'h20; awlen = 0; awburst = 1;
    #1;
    chk("mid_rst_ready", {awready, arready, wready}, 0);
    chk("mid_rst_outs", {bvalid, bresp, rvalid, rlast}, 0);
    chk("mid_rst_mem", {mem_en, mem_bwe, mem_addr}, 0);
    chk("mid_rst_data", {rdata, mem_wdata}, 0);
    tb_last_w = 0;
    @(negedge clk); @(negedge clk);
    rstn = 1; #1;
    chk("post_rst_aw", awready, 1);
    chk("post_rst_no_mem", en_cnt - snap, 0);
    tb_last_w = 1;
    @(negedge clk);
    awvalid = 0;
    wr_data(32'h20, 0, 1, 0, 0, resp);
    rd_addr(32'h20, 0, 1, hs);
    rd_data(32'h20, 0, 1, 0, hs);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/axi4_mem_responder.md
AXI4_MEM_RESPONDER -- requirements
Module: axi4_mem_responder

Interface
REQ-001 Parameters SHALL be:
- DW = 32: data width in bits, power of 2, minimum 32.
- AW = 32: AXI address width.
- MEM_AW = 12: SRAM word-address width.
REQ-002 Ports (name, direction, width, meaning). Clock and reset come first.
- clk  in  1  single clock; all logic is on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- axi4_awvalid/awready  in/out  1/1  write-address handshake.
- axi4_awaddr  in  AW  byte address.
- axi4_awlen  in  8  beats-1.
- axi4_awsize  in  3  beat size.
- axi4_awburst  in  2  burst type.
- axi4_wvalid/wready  in/out  1/1  write-data handshake.
- axi4_wdata  in  DW  write data.
- axi4_wstrb  in  DW/8  byte strobes.
- axi4_wlast  in  1  last write beat.
- axi4_bvalid/bready  out/in  1/1  write-response handshake.
- axi4_bresp  out  2  write response.
- axi4_arvalid/arready  in/out  1/1  read-address handshake.
- axi4_araddr  in  AW  read byte address.
- axi4_arlen  in  8  beats-1.
- axi4_arsize  in  3  beat size.
- axi4_arburst  in  2  burst type.
- axi4_rvalid/rready  out/in  1/1  read-data handshake.
- axi4_rdata  out  DW  read data.
- axi4_rlast  out  1  last read beat.
- mem_en  out  1  SRAM access enable.
- mem_bwe  out  DW/8  byte write enables; all-zero means a read.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_wdata  out  DW  SRAM write data.
- mem_rdata  in  DW  SRAM read data, valid one cycle after a read with mem_en=1.

Function
REQ-003 The block SHALL be an AXI4 slave serving one burst at a time from a single-port SRAM. It is the responder for the copy-engine AXI4 master.
REQ-004 The FSM SHALL have states IDLE, WR_DATA, WR_RESP, RD_DATA.
REQ-005 Arbitration in IDLE:
- awvalid only: grant write.
- arvalid only: grant read.
- both valid: round-robin, granting the type not served last; write wins after reset.
REQ-006 awready or arready SHALL be high only in IDLE, only for the granted channel, and only for one cycle. The handshake cycle latches addr, len and burst.
REQ-007 Word address = addr[MEM_AW+log2(DW/8)-1 : log2(DW/8)]. Address bits above that field that are nonzero mark the burst out of range.
REQ-008 Address advance per beat:
- INCR(01) and WRAP(10): +1, wrapping modulo 2^MEM_AW.
- FIXED(00): address is held.
- size is ignored; every beat is full width.
REQ-009 WR_DATA:
- wready = 1 from the cycle after the AW handshake.
- On each wvalid&wready: mem_en=1, mem_bwe=wstrb, mem_wdata=wdata, mem_addr=current address, all in the same cycle.
- Out-of-range bursts: beats are accepted with mem_en=0.
REQ-010 The beat counter (awlen+1 beats) SHALL end the burst; wlast does not.
REQ-011 bresp SHALL be:
- SLVERR(10) if the burst is out of range, or if wlast disagrees with the counter on any beat.
- OKAY(00) otherwise.
REQ-012 WR_RESP SHALL be entered the cycle after the last beat. bvalid stays high until bready; the FSM returns to IDLE the cycle after the handshake.
REQ-013 RD_DATA SHALL issue SRAM reads (mem_en=1, mem_bwe=0) only when the output buffer has room for every read in flight. Out-of-range reads return zero data.
REQ-014 Read data SHALL pass through a 2-entry output buffer:
- Back-to-back beats with rready held high.
- No beat is lost or duplicated under any rready pattern.
REQ-015 Read latency: AR handshake in cycle N, first SRAM read in N+1, first rvalid in N+2.
REQ-016 rlast SHALL be high on beat arlen+1 only. The FSM goes to IDLE the cycle after that beat's handshake.
REQ-017 While rvalid=1, rdata and rlast SHALL hold stable until rready.
REQ-018 Write and read SRAM accesses SHALL never occur in the same cycle. At most one outstanding burst is allowed; there is no interleaving.

Reset
REQ-019 On rstn low, all of the following SHALL go to 0 asynchronously: every ready, bvalid, bresp, rvalid, rlast, rdata, mem_en, mem_bwe, mem_addr, mem_wdata.
REQ-020 Reset SHALL also clear the FSM to IDLE, empty the buffer, zero the counters and set the round-robin pointer to favour write.
REQ-021 Reset mid-burst SHALL abandon the burst with no further SRAM access. The first cycle after reset release with awvalid high SHALL see awready asserted in that cycle.

Structure
REQ-022 Package axi4_resp_pkg SHALL hold:
- the state enum;
- burst encodings FIXED/INCR/WRAP;
- response constants OKAY=2'b00, SLVERR=2'b10.
REQ-023 The read output buffer SHALL be sub-module axi4_rd_skid: 2 entries, DW+1 bits wide (data plus last), with valid/ready on both sides.

Verification
REQ-024 Bench directed scenarios:
- Single write: awaddr=0x10, awlen=0, wdata=0xA5A5A5A5, wstrb=0xF -> mem_addr=4, bresp=00; a following read of 0x10 returns 0xA5A5A5A5 with rlast=1, rvalid two cycles after the AR handshake.
- INCR read burst: araddr=0x0, arlen=7, rready toggled every cycle -> 8 beats, in order, none lost or duplicated, rlast only on beat 8.
- awvalid and arvalid high together on 3 consecutive bursts -> grants W, R, W.
- Write with awlen=3 and wlast high on beat 2 -> 4 beats written, bresp=10.
- Out-of-range and FIXED:
  - awaddr=0x10000 -> no mem_en, bresp=10.
  - FIXED arlen=3 at 0x8 -> 4 reads at mem_addr=2.
- rstn pulsed low during beat 3 of a 16-beat read -> all outputs 0 immediately; a new AW is accepted right after release.
